cpu_rtype_pipe: RTL and testbench
=================================

CPU_RTYPE_PIPE -- requirements
Module: cpu_rtype_pipe

Interface
REQ-001 SHALL take parameter DATA_W, default 32: datapath, register and result width.
REQ-002 SHALL take parameter REG_N, default 32: number of registers, power of two, at most 32.
REQ-003 SHALL take parameter IMEM_DEPTH, default 64: number of instruction words, power of two.
REQ-004 SHALL have port clk_CPU, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_CPU_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: one-cycle run request.
REQ-007 SHALL have port resultado, output, DATA_W: ALU result of the most recently retired instruction.
REQ-008 SHALL have port wb_valid, output, 1: high for exactly one cycle per retired instruction.
REQ-009 SHALL have port wb_addr, output, 5: rd field of the retired instruction.
REQ-010 SHALL have port halted, output, 1: pipeline drained after a HALT word.
REQ-011 SHALL have port err, output, 1: sticky flag for an illegal funct or a PC overrun.
REQ-012 SHALL have port retired, output, 32: count of retired instructions since the last start.

Function
REQ-013 SHALL hold instruction words in 32-bit array IM.instBank[IMEM_DEPTH] and registers in BR.registerBank[REG_N], both loadable by $readmemb from the bench.
REQ-014 SHALL use a 3-stage pipeline: IF registers instBank[PC] into IF/ID; ID registers operands rs/rt into ID/EX; EX computes and writes rd on the same edge.
REQ-015 SHALL support only R-type words (opcode 0) with funct codes ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, NOR 0x27 and SLT 0x2A (signed compare, result zero-extended to 1).
REQ-016 SHALL do arithmetic modulo 2^DATA_W with no overflow trap; register indices SHALL use the low log2(REG_N) bits of each field.
REQ-017 SHALL treat the all-zero word as NOP: no register write, no wb_valid pulse, not counted in retired.
REQ-018 SHALL, for any other unsupported funct or nonzero opcode other than 0x3F, set err and treat the word as NOP.
REQ-019 SHALL treat opcode 0x3F as HALT: fetching stops and already-fetched older instructions complete.
REQ-020 SHALL implement FSM IDLE->RUN on start; RUN->DRAIN when HALT is decoded; DRAIN->HALT after 2 cycles; HALT->RUN on start.
REQ-021 SHALL clear PC, retired and err and flush pipeline registers on every accepted start; start in RUN or DRAIN SHALL be ignored.
REQ-022 SHALL make the first instruction's wb_valid rise 3 edges after the edge that samples start, then sustain one retirement per cycle with no stalls.
REQ-023 SHALL forward the EX-stage result into ID operand capture when the EX rd matches rs or rt and rd is nonzero; this is the only hazard path.
REQ-024 SHALL hardwire register 0 to zero: writes to it are discarded, but wb_valid still pulses and resultado shows the ALU value.
REQ-025 SHALL, when PC would pass IMEM_DEPTH-1 without a HALT, set err and enter DRAIN (no wrap).
REQ-026 SHALL pulse wb_valid together with updates of resultado, wb_addr and retired.

Reset
REQ-027 SHALL on rst_CPU_n low immediately force FSM IDLE, PC 0, pipeline valids 0, resultado 0, wb_valid 0, wb_addr 0, halted 0, err 0 and retired 0.
REQ-028 SHALL NOT clear instBank or registerBank on reset, so preloaded contents survive.
REQ-029 SHALL, on reset mid-RUN, lose in-flight instructions with no partial register write on the asserting edge.

Structure
REQ-030 SHALL place funct/opcode constants, FSM state encoding and the HALT opcode in shared package cpu_pkg.
REQ-031 SHALL implement the ALU as sub-module alu_rtype (parameter DATA_W, combinational), instantiated once in EX.

Verification
REQ-032 SHALL test basic run: $1=5, $2=3, program ADD $3,$1,$2; HALT; start -> resultado=8, wb_addr=3 three edges after start; halted=1; retired=1.
REQ-033 SHALL test forwarding: ADD $3,$1,$2 then SUB $4,$3,$1 back-to-back -> second resultado=3, no stall cycle.
REQ-034 SHALL test SLT/NOR: $1=-1, $2=1; SLT $5,$1,$2 -> 1; NOR $6,$0,$0 -> all ones.
REQ-035 SHALL test $0 and errors: ADD $0,$1,$2 -> wb_valid pulses, $0 stays 0; funct 0x3B -> err=1, retired unchanged.
REQ-036 SHALL test overrun/reset: a program with no HALT sets err and halted at the end of memory; rst_CPU_n low mid-RUN clears all outputs while registerBank contents persist.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the R-type pipeline: opcodes, funct codes, FSM states
// and the instruction classifier used by the decode stage.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    C_NOP  = 2'd0,
    C_ALU  = 2'd1,
    C_HALT = 2'd2,
    C_ILL  = 2'd3
  } iclass_e;

  // The all-zero word is a silent NOP; anything unrecognised is illegal.
  function automatic iclass_e decode_class(input logic [31:0] w);
    if (w == 32'd0) return C_NOP;
    if (w[31:26] == OP_HALT) return C_HALT;
    if (w[31:26] == OP_RTYPE) begin
      case (w[5:0])
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: return C_ALU;
        default: ;
      endcase
    end
    return C_ILL;
  endfunction

endpackage

// File: rtl/alu_rtype.sv
// Combinational R-type ALU: modulo-2^DATA_W add/sub, bitwise ops and a
// signed set-less-than that yields 0 or 1.
module alu_rtype
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    y = '0;
    case (funct)
      FN_ADD:  y = a + b;
      FN_SUB:  y = a - b;
      FN_AND:  y = a & b;
      FN_OR:   y = a | b;
      FN_NOR:  y = ~(a | b);
      FN_SLT:  y = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_rtype_pipe.sv
// Three-stage (IF / ID / EX) R-type CPU with a run/drain/halt controller,
// EX->ID operand forwarding and a retire counter.
module cpu_rtype_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_N      = 32,
  parameter int IMEM_DEPTH = 64
) (
  input  logic              clk_CPU,
  input  logic              rst_CPU_n,
  input  logic              start,
  output logic [DATA_W-1:0] resultado,
  output logic              wb_valid,
  output logic [4:0]        wb_addr,
  output logic              halted,
  output logic              err,
  output logic [31:0]       retired
);

  localparam int RIDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam int PC_W   = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(IMEM_DEPTH - 1);

  state_e              state_q, state_d;
  logic                drain_cnt_q, drain_cnt_d;
  logic [PC_W-1:0]     pc_q, pc_d;

  logic                vld_p1_q, vld_p1_d;
  logic [31:0]         instr_p1_q, instr_p1_d;

  logic                vld_p2_q, vld_p2_d;
  logic [DATA_W-1:0]   opa_p2_q, opa_p2_d;
  logic [DATA_W-1:0]   opb_p2_q, opb_p2_d;
  logic [5:0]          funct_p2_q, funct_p2_d;
  logic [4:0]          rd_p2_q, rd_p2_d;

  logic [DATA_W-1:0]   resultado_q, resultado_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_addr_q, wb_addr_d;
  logic                err_q, err_d;
  logic [31:0]         retired_q, retired_d;

  logic                start_acc;
  iclass_e             id_class;
  logic                halt_in_id;
  logic                fetch_en;
  logic                overrun;
  logic [31:0]         fetch_word;
  logic [RIDX_W-1:0]   rs_idx, rt_idx, rf_waddr;
  logic [DATA_W-1:0]   rs_val, rt_val;
  logic                fwd_ok;
  logic                rf_we;
  logic [DATA_W-1:0]   alu_y;

  // Storage arrays live in named scopes so the bench can preload them.
  if (1'b1) begin : IM
    logic [31:0] instBank [IMEM_DEPTH];
  end

  if (1'b1) begin : BR
    logic [DATA_W-1:0] registerBank [REG_N];
    always_ff @(posedge clk_CPU) begin
      if (rf_we) registerBank[rf_waddr] <= alu_y;
    end
  end

  assign start_acc  = start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign id_class   = decode_class(instr_p1_q);
  assign halt_in_id = vld_p1_q && (id_class == C_HALT);
  assign fetch_word = IM.instBank[pc_q];
  assign fetch_en   = (state_q == S_RUN) && !halt_in_id;
  // A HALT sitting in the last word ends the program normally, not as an overrun.
  assign overrun    = fetch_en && (pc_q == PC_LAST) && (fetch_word[31:26] != OP_HALT);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_HALT: if (start) state_d = S_RUN;
      S_RUN: begin
        if (halt_in_id || overrun) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q) state_d = S_HALT;
        else             drain_cnt_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF stage -> IF/ID
  always_comb begin
    pc_d       = pc_q;
    instr_p1_d = instr_p1_q;
    vld_p1_d   = 1'b0;
    if (start_acc) begin
      pc_d = '0;
    end else if (fetch_en) begin
      instr_p1_d = fetch_word;
      vld_p1_d   = 1'b1;
      pc_d       = pc_q + 1'b1;
    end
  end

  // ID stage -> ID/EX, with the EX result bypassed over a same-edge write
  assign rs_idx   = instr_p1_q[21 +: RIDX_W];
  assign rt_idx   = instr_p1_q[16 +: RIDX_W];
  assign rf_waddr = rd_p2_q[RIDX_W-1:0];
  assign fwd_ok   = vld_p2_q && (rf_waddr != '0);

  always_comb begin
    rs_val = (rs_idx == '0) ? '0 : BR.registerBank[rs_idx];
    rt_val = (rt_idx == '0) ? '0 : BR.registerBank[rt_idx];
    if (fwd_ok && (rf_waddr == rs_idx)) rs_val = alu_y;
    if (fwd_ok && (rf_waddr == rt_idx)) rt_val = alu_y;
  end

  always_comb begin
    vld_p2_d   = vld_p1_q && (id_class == C_ALU) && !start_acc;
    opa_p2_d   = rs_val;
    opb_p2_d   = rt_val;
    funct_p2_d = instr_p1_q[5:0];
    rd_p2_d    = instr_p1_q[15:11];
  end

  // EX stage -> register file and writeback outputs
  alu_rtype #(.DATA_W(DATA_W)) u_alu (
    .funct (funct_p2_q),
    .a     (opa_p2_q),
    .b     (opb_p2_q),
    .y     (alu_y)
  );

  assign rf_we = vld_p2_q && rst_CPU_n && (rf_waddr != '0);

  always_comb begin
    wb_valid_d  = vld_p2_q && !start_acc;
    resultado_d = vld_p2_q ? alu_y   : resultado_q;
    wb_addr_d   = vld_p2_q ? rd_p2_q : wb_addr_q;
    retired_d   = start_acc ? 32'd0 : (retired_q + 32'(vld_p2_q));
    err_d       = start_acc ? 1'b0
                            : (err_q || (vld_p1_q && (id_class == C_ILL)) || overrun);
  end

  always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
    if (!rst_CPU_n) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 1'b0;
      pc_q        <= '0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      resultado_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      err_q       <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pc_q        <= pc_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      resultado_q <= resultado_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      err_q       <= err_d;
      retired_q   <= retired_d;
    end
  end

  always_ff @(posedge clk_CPU) begin
    instr_p1_q <= instr_p1_d;
    opa_p2_q   <= opa_p2_d;
    opb_p2_q   <= opb_p2_d;
    funct_p2_q <= funct_p2_d;
    rd_p2_q    <= rd_p2_d;
  end

  assign resultado = resultado_q;
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign halted    = (state_q == S_HALT);
  assign err       = err_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_rtype_pipe.sv
// Directed bench for cpu_rtype_pipe: small programs are placed in instruction
// memory, registers are built up by the programs themselves, results are logged.
module tb_cpu_rtype_pipe;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [31:0] W_HALT = 32'hFC00_0000;

  logic        clk_CPU;
  logic        rst_CPU_n;
  logic        start;
  logic [31:0] resultado;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        halted;
  logic        err;
  logic [31:0] retired;

  cpu_rtype_pipe dut (
    .clk_CPU   (clk_CPU),
    .rst_CPU_n (rst_CPU_n),
    .start     (start),
    .resultado (resultado),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .halted    (halted),
    .err       (err),
    .retired   (retired)
  );

  initial clk_CPU = 1'b0;
  always #5 clk_CPU = ~clk_CPU;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } ret_t;

  ret_t log_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk_CPU) cyc <= cyc + 1;

  always @(negedge clk_CPU) begin
    if (wb_valid) log_q.push_back('{wb_addr, resultado, cyc});
  end

  function automatic logic [31:0] rt(input int rd, input int rs, input int rtr, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rtr), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [63:0] log_a(input int i);
    if (i < log_q.size()) return {59'd0, log_q[i].a};
    return 64'hBAD0_0000_0000_0000;
  endfunction

  function automatic logic [63:0] log_d(input int i);
    if (i < log_q.size()) return {32'd0, log_q[i].d};
    return 64'hBAD0_0000_0000_0000;
  endfunction

  function automatic logic [63:0] log_gap(input int i);
    if (i + 1 < log_q.size()) return 64'(log_q[i+1].c - log_q[i].c);
    return 64'hBAD0_0000_0000_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fill_im(input logic [31:0] w);
    for (int i = 0; i < 64; i++) dut.IM.instBank[i] = w;
  endtask

  task automatic start_pulse();
    @(posedge clk_CPU); #1;
    log_q.delete();
    start = 1'b1;
    @(posedge clk_CPU); #1;
    start = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(posedge clk_CPU); #1;
      k++;
    end
    check({tag, "_halted"}, 64'(halted), 64'd1);
  endtask

  initial begin
    rst_CPU_n = 1'b0;
    start     = 1'b0;
    repeat (2) @(posedge clk_CPU);
    #1;
    check("rst_resultado", 64'(resultado), 64'd0);
    check("rst_wb_valid",  64'(wb_valid),  64'd0);
    check("rst_wb_addr",   64'(wb_addr),   64'd0);
    check("rst_halted",    64'(halted),    64'd0);
    check("rst_err",       64'(err),       64'd0);
    check("rst_retired",   64'(retired),   64'd0);
    rst_CPU_n = 1'b1;

    // Setup: $1=5, $2=3 built from $0 through a chain of forwarded results.
    fill_im(32'd0);
    dut.IM.instBank[0] = rt(1, 0, 0, F_NOR);
    dut.IM.instBank[1] = rt(2, 0, 1, F_SUB);
    dut.IM.instBank[2] = rt(3, 2, 2, F_ADD);
    dut.IM.instBank[3] = rt(4, 3, 2, F_ADD);
    dut.IM.instBank[4] = rt(1, 4, 3, F_ADD);
    dut.IM.instBank[5] = rt(2, 4, 0, F_ADD);
    dut.IM.instBank[6] = W_HALT;
    start_pulse();
    wait_halted("setup", 40);
    check("setup_retired", 64'(retired), 64'd6);
    check("setup_err",     64'(err),     64'd0);
    check("setup_d0", log_d(0), 64'hFFFF_FFFF);
    check("setup_d1", log_d(1), 64'd1);
    check("setup_d3", log_d(3), 64'd3);
    check("setup_d4", log_d(4), 64'd5);
    check("setup_a4", log_a(4), 64'd1);
    check("setup_d5", log_d(5), 64'd3);

    // Basic run: ADD $3,$1,$2 ; HALT, with exact writeback latency.
    fill_im(32'd0);
    dut.IM.instBank[0] = rt(3, 1, 2, F_ADD);
    dut.IM.instBank[1] = W_HALT;
    start_pulse();
    check("basic_halted_clr", 64'(halted), 64'd0);
    @(posedge clk_CPU); #1;
    @(posedge clk_CPU); #1;
    check("basic_wbv_e2", 64'(wb_valid), 64'd0);
    @(posedge clk_CPU); #1;
    check("basic_wbv_e3", 64'(wb_valid),  64'd1);
    check("basic_res",    64'(resultado), 64'd8);
    check("basic_addr",   64'(wb_addr),   64'd3);
    check("basic_ret_e3", 64'(retired),   64'd1);
    @(posedge clk_CPU); #1;
    check("basic_wbv_e4", 64'(wb_valid), 64'd0);
    wait_halted("basic", 20);
    check("basic_retired", 64'(retired), 64'd1);
    check("basic_err",     64'(err),     64'd0);

    // Forwarding: ADD $3,$1,$2 ; SUB $4,$3,$1 back to back.
    fill_im(32'd0);
    dut.IM.instBank[0] = rt(3, 1, 2, F_ADD);
    dut.IM.instBank[1] = rt(4, 3, 1, F_SUB);
    dut.IM.instBank[2] = W_HALT;
    start_pulse();
    wait_halted("fwd", 20);
    check("fwd_d0",  log_d(0),   64'd8);
    check("fwd_d1",  log_d(1),   64'd3);
    check("fwd_a1",  log_a(1),   64'd4);
    check("fwd_gap", log_gap(0), 64'd1);
    check("fwd_retired", 64'(retired), 64'd2);

    // SLT / NOR with $1=-1, $2=1.
    fill_im(32'd0);
    dut.IM.instBank[0] = rt(1, 0, 0, F_NOR);
    dut.IM.instBank[1] = rt(2, 0, 1, F_SUB);
    dut.IM.instBank[2] = rt(5, 1, 2, F_SLT);
    dut.IM.instBank[3] = rt(7, 2, 1, F_SLT);
    dut.IM.instBank[4] = rt(6, 0, 0, F_NOR);
    dut.IM.instBank[5] = W_HALT;
    start_pulse();
    wait_halted("slt", 30);
    check("slt_neg_lt_pos", log_d(2), 64'd1);
    check("slt_pos_lt_neg", log_d(3), 64'd0);
    check("nor_zero",       log_d(4), 64'hFFFF_FFFF);
    check("nor_addr",       log_a(4), 64'd6);
    check("slt_retired", 64'(retired), 64'd5);

    // $0 writes and an illegal funct.
    fill_im(32'd0);
    dut.IM.instBank[0] = rt(0, 1, 1, F_ADD);
    dut.IM.instBank[1] = rt(8, 0, 2, F_OR);
    dut.IM.instBank[2] = rt(9, 1, 2, 6'h3B);
    dut.IM.instBank[3] = rt(9, 1, 2, F_AND);
    dut.IM.instBank[4] = W_HALT;
    start_pulse();
    wait_halted("zero", 30);
    check("zero_addr",   log_a(0), 64'd0);
    check("zero_res",    log_d(0), 64'hFFFF_FFFE);
    check("zero_read",   log_d(1), 64'd1);
    check("ill_skip_d",  log_d(2), 64'd1);
    check("ill_skip_a",  log_a(2), 64'd9);
    check("ill_retired", 64'(retired), 64'd3);
    check("ill_err",     64'(err),     64'd1);

    // Overrun: 64 words with no HALT; a start mid-run is ignored.
    fill_im(rt(10, 2, 2, F_ADD));
    start_pulse();
    check("ovr_err_cleared", 64'(err),     64'd0);
    check("ovr_ret_cleared", 64'(retired), 64'd0);
    repeat (10) @(posedge clk_CPU);
    #1;
    start = 1'b1;
    @(posedge clk_CPU); #1;
    start = 1'b0;
    wait_halted("ovr", 200);
    check("ovr_err",     64'(err),     64'd1);
    check("ovr_retired", 64'(retired), 64'd64);
    check("ovr_reg10",   64'(dut.BR.registerBank[10]), 64'd2);

    // Asynchronous reset in the middle of a run.
    fill_im(rt(11, 1, 1, F_ADD));
    start_pulse();
    repeat (10) @(posedge clk_CPU);
    #3;
    rst_CPU_n = 1'b0;
    #1;
    check("mid_rst_resultado", 64'(resultado), 64'd0);
    check("mid_rst_wb_valid",  64'(wb_valid),  64'd0);
    check("mid_rst_wb_addr",   64'(wb_addr),   64'd0);
    check("mid_rst_halted",    64'(halted),    64'd0);
    check("mid_rst_err",       64'(err),       64'd0);
    check("mid_rst_retired",   64'(retired),   64'd0);
    check("keep_reg10", 64'(dut.BR.registerBank[10]), 64'd2);
    check("keep_reg11", 64'(dut.BR.registerBank[11]), 64'hFFFF_FFFE);
    check("keep_reg8",  64'(dut.BR.registerBank[8]),  64'd1);
    check("keep_reg5",  64'(dut.BR.registerBank[5]),  64'd1);
    @(posedge clk_CPU); #1;
    rst_CPU_n = 1'b1;
    log_q.delete();
    repeat (5) @(posedge clk_CPU);
    #1;
    check("idle_no_retire", 64'(log_q.size()), 64'd0);
    check("idle_retired",   64'(retired),      64'd0);
    check("idle_halted",    64'(halted),       64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
